demux3_out: RTL and testbench

- Registered 1-to-3 stream distributor: the return/fan-out counterpart of the 3-input 32-bit data selector in the CPU datapath.
- Accepts one word per handshake with a 2-bit `Order` select and delivers it to exactly one of three downstream consumers, each through a one-entry output buffer with valid/ready.
- Uses the same `Order` encoding as the selector side; the unused code is counted as an error and dropped.

---
 rtl/demux3_out_pkg.sv | 18 +
 rtl/demux3_out_slot.sv | 37 +++
 rtl/demux3_out.sv | 94 +++++++++
 tb/tb_demux3_out.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/demux3_out_pkg.sv
// Shared definitions for the 3-way data selector and its fan-out counterpart.
package cpu_mux_pkg;

  typedef logic [1:0] order_t;

  localparam order_t SIGN0    = 2'b00;
  localparam order_t SIGN1    = 2'b01;
  localparam order_t SIGN2    = 2'b10;
  localparam order_t SIGN_ILL = 2'b11;

  localparam int NUM_SLOTS = 3;

  // True when the order code names a real destination.
  function automatic logic isLegal(input order_t ord);
    return ord != SIGN_ILL;
  endfunction

endpackage

// File: rtl/demux3_out_slot.sv
// One-entry output buffer with valid/ready. A pop and a write in the same
// cycle keep the slot full with the new word (pass-through refill).
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             can_write
);

  logic             fullReg;
  logic [WIDTH-1:0] dataReg;

  // Occupancy and stored word; the word is kept after a pop so the output
  // holds its last value while not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fullReg <= 1'b0;
      dataReg <= '0;
    end else if (wr_en) begin
      fullReg <= 1'b1;
      dataReg <= wr_data;
    end else if (rd_ready) begin
      fullReg <= 1'b0;
    end
  end

  assign full      = fullReg;
  assign data      = dataReg;
  assign can_write = ~fullReg | rd_ready;

endmodule

// File: rtl/demux3_out.sv
// Registered 1-to-3 stream distributor. Each accepted word goes to the slot
// named by Order; the unused code is swallowed and counted as an error.
module demux3_out
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       Order,
  input  logic [WIDTH-1:0] DataIn,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] DataOut0,
  output logic [WIDTH-1:0] DataOut1,
  output logic [WIDTH-1:0] DataOut2,
  output logic             err_illegal,
  output logic [ERRW-1:0]  err_cnt
);

  order_t                  orderSel;
  logic [NUM_SLOTS-1:0]    canWrite;
  logic [NUM_SLOTS-1:0]    slotFull;
  logic [NUM_SLOTS-1:0]    wrEn;
  logic [WIDTH-1:0]        slotData [NUM_SLOTS];
  logic                    readyMux;
  logic                    accept;
  logic                    illAccept;
  logic                    errIllegalReg;
  logic [ERRW-1:0]         errCntReg;

  assign orderSel = order_t'(Order);

  // Ready follows the addressed slot only; an illegal code is always taken
  // so it can be dropped without waiting on any consumer.
  always_comb begin
    readyMux = 1'b0;
    case (orderSel)
      SIGN0:   readyMux = canWrite[0];
      SIGN1:   readyMux = canWrite[1];
      SIGN2:   readyMux = canWrite[2];
      default: readyMux = 1'b1;
    endcase
  end

  // Holding ready low in reset makes any handshake in that cycle a no-op.
  assign in_ready  = ~rst & readyMux;
  assign accept    = in_valid & in_ready;
  assign illAccept = accept & ~isLegal(orderSel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : gSlot
      assign wrEn[gi] = accept & (orderSel == order_t'(gi));

      demux_slot #(
        .WIDTH(WIDTH)
      ) uSlot (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wrEn[gi]),
        .wr_data  (DataIn),
        .rd_ready (out_ready[gi]),
        .full     (slotFull[gi]),
        .data     (slotData[gi]),
        .can_write(canWrite[gi])
      );
    end
  endgenerate

  // Error pulse follows each illegal accept; the counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      errIllegalReg <= 1'b0;
      errCntReg     <= '0;
    end else begin
      errIllegalReg <= illAccept;
      if (illAccept && (errCntReg != {ERRW{1'b1}})) begin
        errCntReg <= errCntReg + ERRW'(1);
      end
    end
  end

  assign out_valid   = slotFull;
  assign DataOut0    = slotData[0];
  assign DataOut1    = slotData[1];
  assign DataOut2    = slotData[2];
  assign err_illegal = errIllegalReg;
  assign err_cnt     = errCntReg;

endmodule

// File: tb/tb_demux3_out.sv
// Bench for demux3_out: directed scenarios followed by random traffic, all
// compared against a slot-occupancy model updated once per clock.
module tb_demux3_out;

  localparam int WIDTH = 32;
  localparam int ERRW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       Order;
  logic [WIDTH-1:0] DataIn;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] DataOut0;
  logic [WIDTH-1:0] DataOut1;
  logic [WIDTH-1:0] DataOut2;
  logic             err_illegal;
  logic [ERRW-1:0]  err_cnt;

  always #5 clk = ~clk;

  demux3_out #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Order      (Order),
    .DataIn     (DataIn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .DataOut0   (DataOut0),
    .DataOut1   (DataOut1),
    .DataOut2   (DataOut2),
    .err_illegal(err_illegal),
    .err_cnt    (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: which destinations hold a word, and the last word
  // written to each destination.
  bit          mFull [3];
  logic [31:0] mData [3];
  bit          mErr;
  int          mCnt;
  bit          lastAccepted;

  function automatic bit expReady();
    if (rst) return 1'b0;
    if (Order == 2'd3) return 1'b1;
    return !mFull[Order] || out_ready[Order];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input bit v, input logic [1:0] o, input logic [31:0] d,
                       input logic [2:0] r, input bit rs);
    in_valid  = v;
    Order     = o;
    DataIn    = d;
    out_ready = r;
    rst       = rs;
  endtask

  // Check every output against the model, clock once, advance the model.
  task automatic cycle();
    bit acc;
    #1;
    chk("in_ready",    {63'd0, in_ready}, {63'd0, expReady()});
    chk("out_valid",   {61'd0, out_valid}, {61'd0, mFull[2], mFull[1], mFull[0]});
    chk("DataOut0",    {32'd0, DataOut0}, {32'd0, mData[0]});
    chk("DataOut1",    {32'd0, DataOut1}, {32'd0, mData[1]});
    chk("DataOut2",    {32'd0, DataOut2}, {32'd0, mData[2]});
    chk("err_illegal", {63'd0, err_illegal}, {63'd0, mErr});
    chk("err_cnt",     {56'd0, err_cnt}, 64'(mCnt));
    acc = in_valid && expReady();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mFull[k] = 1'b0;
        mData[k] = '0;
      end
      mErr = 1'b0;
      mCnt = 0;
      acc  = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) if (mFull[k] && out_ready[k]) mFull[k] = 1'b0;
      mErr = 1'b0;
      if (acc) begin
        if (Order == 2'd3) begin
          mErr = 1'b1;
          if (mCnt < 255) mCnt++;
          $display("t=%0t accept illegal order, dropped (count %0d)", $time, mCnt);
        end else begin
          mFull[Order] = 1'b1;
          mData[Order] = DataIn;
          $display("t=%0t accept slot %0d data=%08h", $time, Order, DataIn);
        end
      end
    end
    lastAccepted = acc;
    @(negedge clk);
  endtask

  bit prevHold;

  initial begin
    for (int k = 0; k < 3; k++) begin
      mFull[k] = 1'b0;
      mData[k] = '0;
    end
    mErr = 1'b0;
    mCnt = 0;
    lastAccepted = 1'b0;

    // Reset, with a handshake offered that must be ignored.
    setIn(1'b1, 2'd0, 32'hDEADBEEF, 3'b111, 1'b1);
    @(negedge clk);
    cycle();
    setIn(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
    cycle();

    // Single word to slot 1, popped the following cycle.
    setIn(1'b1, 2'd1, 32'h12345678, 3'b111, 1'b0);
    cycle();
    setIn(1'b0, 2'd0, 32'h0, 3'b111, 1'b0);
    chk("t1_valid", {61'd0, out_valid}, 64'h2);
    chk("t1_data",  {32'd0, DataOut1}, 64'h12345678);
    cycle();
    chk("t1_clear", {61'd0, out_valid}, 64'h0);
    cycle();

    // Stall on a full slot, then pass-through refill.
    setIn(1'b1, 2'd0, 32'hAAAA0001, 3'b000, 1'b0);
    cycle();
    setIn(1'b1, 2'd0, 32'hAAAA0002, 3'b000, 1'b0);
    #1 chk("t2_stall", {63'd0, in_ready}, 64'h0);
    cycle();
    out_ready = 3'b001;
    #1 chk("t2_refill_rdy", {63'd0, in_ready}, 64'h1);
    cycle();
    setIn(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
    chk("t2_valid", {61'd0, out_valid}, 64'h1);
    chk("t2_data",  {32'd0, DataOut0}, 64'hAAAA0002);
    cycle();

    // Fill all three slots, then drain them together.
    setIn(1'b0, 2'd0, 32'h0, 3'b111, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      setIn(1'b1, 2'(k), 32'hB0B00000 + 32'(k), 3'b000, 1'b0);
      cycle();
    end
    setIn(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
    chk("t3_full", {61'd0, out_valid}, 64'h7);
    chk("t3_d2",   {32'd0, DataOut2}, 64'hB0B00002);
    out_ready = 3'b111;
    cycle();
    out_ready = 3'b000;
    chk("t3_empty", {61'd0, out_valid}, 64'h0);
    cycle();

    // 300 illegal orders back to back.
    for (int i = 0; i < 300; i++) begin
      setIn(1'b1, 2'd3, $urandom, 3'($urandom), 1'b0);
      cycle();
    end
    setIn(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
    chk("t4_pulse", {63'd0, err_illegal}, 64'h1);
    chk("t4_sat",   {56'd0, err_cnt}, 64'd255);
    cycle();
    chk("t4_pulse_end", {63'd0, err_illegal}, 64'h0);

    // Reset while slots 0 and 2 are full and a word targets slot 1.
    setIn(1'b1, 2'd0, 32'hC0000000, 3'b000, 1'b0);
    cycle();
    setIn(1'b1, 2'd2, 32'hC0000002, 3'b000, 1'b0);
    cycle();
    setIn(1'b1, 2'd1, 32'hC0000001, 3'b000, 1'b1);
    cycle();
    setIn(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
    chk("t5_valid", {61'd0, out_valid}, 64'h0);
    chk("t5_d0",    {32'd0, DataOut0}, 64'h0);
    chk("t5_d1",    {32'd0, DataOut1}, 64'h0);
    chk("t5_cnt",   {56'd0, err_cnt}, 64'h0);
    cycle();

    // Random traffic; a stalled word is held until it is taken.
    prevHold = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (prevHold) begin
        in_valid = 1'b1;
      end else begin
        int r;
        r        = $urandom_range(0, 7);
        Order    = (r == 7) ? 2'd3 : 2'(r % 3);
        DataIn   = $urandom;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = 3'($urandom);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
      prevHold = in_valid && !lastAccepted && !rst;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
